// File: rtl/dmem_axi_master_if.sv
// AXI4 bus bundle between the data-memory bridge (master) and the interconnect (slave).
interface dmem_axi_master_if #(
  parameter int unsigned ADDR_BITS = 32,
  parameter int unsigned DATA_BITS = 32,
  parameter int unsigned ID_BITS   = 4
);
  localparam int unsigned STRB_BITS = DATA_BITS / 8;

  logic [ID_BITS-1:0]   AWID;
  logic [ADDR_BITS-1:0] AWADDR;
  logic [7:0]           AWLEN;
  logic [2:0]           AWSIZE;
  logic [1:0]           AWBURST;
  logic                 AWVALID;
  logic                 AWREADY;

  logic [DATA_BITS-1:0] WDATA;
  logic [STRB_BITS-1:0] WSTRB;
  logic                 WLAST;
  logic                 WVALID;
  logic                 WREADY;

  logic [ID_BITS-1:0]   BID;
  logic [1:0]           BRESP;
  logic                 BVALID;
  logic                 BREADY;

  logic [ID_BITS-1:0]   ARID;
  logic [ADDR_BITS-1:0] ARADDR;
  logic [7:0]           ARLEN;
  logic [2:0]           ARSIZE;
  logic [1:0]           ARBURST;
  logic                 ARVALID;
  logic                 ARREADY;

  logic [ID_BITS-1:0]   RID;
  logic [DATA_BITS-1:0] RDATA;
  logic [1:0]           RRESP;
  logic                 RLAST;
  logic                 RVALID;
  logic                 RREADY;

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY
  );

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY
  );
endinterface

// File: rtl/dmem_axi_master.sv
// CPU data-memory port to AXI4 master bridge: one single-beat AXI transaction per request.
// Optional macro DMEM_AXI_ERR_EN adds a sticky first-error flag and address (err_o/err_addr_o).
module dmem_axi_master #(
  parameter int unsigned AXI_ADDR_BITS = 32,
  parameter int unsigned AXI_DATA_BITS = 32,
  parameter int unsigned AXI_ID_BITS   = 4,
  parameter int unsigned MASTER_ID     = 1
) (
  input  logic                       ACLK,
  input  logic                       ARESETn,
  input  logic [AXI_ADDR_BITS-1:0]   dmem_addr,
  input  logic                       dmem_ren,
  input  logic                       dmem_wen,
  input  logic [AXI_DATA_BITS/8-1:0] dmem_wstrb,
  input  logic [AXI_DATA_BITS-1:0]   dmem_wdata,
  output logic [AXI_DATA_BITS-1:0]   dmem_rdata,
  output logic                       stall_o,
`ifdef DMEM_AXI_ERR_EN
  output logic                       err_o,
  output logic [AXI_ADDR_BITS-1:0]   err_addr_o,
`endif
  dmem_axi_master_if.master          m_axi
);

  localparam int unsigned STRB_BITS = AXI_DATA_BITS / 8;
  localparam logic [7:0]  AX_LEN    = 8'd0;
  localparam logic [2:0]  AX_SIZE   = 3'b010;
  localparam logic [1:0]  AX_BURST  = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADDR = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR_REQ  = 3'd3,
    S_WR_RESP = 3'd4,
    S_DONE    = 3'd5
  } state_e;

  state_e                   r_state, w_state_nxt;
  logic [AXI_ADDR_BITS-1:0] r_addr, w_addr_nxt;
  logic [AXI_DATA_BITS-1:0] r_wdata, w_wdata_nxt;
  logic [STRB_BITS-1:0]     r_wstrb, w_wstrb_nxt;
  logic [AXI_DATA_BITS-1:0] r_rdata, w_rdata_nxt;
  logic                     r_arvalid, w_arvalid_nxt;
  logic                     r_rready, w_rready_nxt;
  logic                     r_awvalid, w_awvalid_nxt;
  logic                     r_wvalid, w_wvalid_nxt;
  logic                     r_bready, w_bready_nxt;
  logic                     w_resp_err;

  // Next-state and next registered-output logic; VALID/READY are registered from the next state.
  always_comb begin
    w_state_nxt   = r_state;
    w_addr_nxt    = r_addr;
    w_wdata_nxt   = r_wdata;
    w_wstrb_nxt   = r_wstrb;
    w_rdata_nxt   = r_rdata;
    w_arvalid_nxt = 1'b0;
    w_rready_nxt  = 1'b0;
    w_awvalid_nxt = 1'b0;
    w_wvalid_nxt  = 1'b0;
    w_bready_nxt  = 1'b0;
    w_resp_err    = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (dmem_wen) begin
          w_addr_nxt    = dmem_addr;
          w_wdata_nxt   = dmem_wdata;
          w_wstrb_nxt   = dmem_wstrb;
          w_awvalid_nxt = 1'b1;
          w_wvalid_nxt  = 1'b1;
          w_state_nxt   = S_WR_REQ;
        end else if (dmem_ren) begin
          w_addr_nxt    = dmem_addr;
          w_arvalid_nxt = 1'b1;
          w_state_nxt   = S_RD_ADDR;
        end
      end
      S_RD_ADDR: begin
        if (r_arvalid && m_axi.ARREADY) begin
          w_rready_nxt = 1'b1;
          w_state_nxt  = S_RD_DATA;
        end else begin
          w_arvalid_nxt = 1'b1;
        end
      end
      S_RD_DATA: begin
        if (r_rready && m_axi.RVALID) begin
          w_rdata_nxt = m_axi.RDATA;
          w_resp_err  = |m_axi.RRESP;
          w_state_nxt = S_DONE;
        end else begin
          w_rready_nxt = 1'b1;
        end
      end
      S_WR_REQ: begin
        // AW and W retire independently; a dropped VALID marks that channel as done.
        w_awvalid_nxt = r_awvalid & ~m_axi.AWREADY;
        w_wvalid_nxt  = r_wvalid & ~m_axi.WREADY;
        if (!w_awvalid_nxt && !w_wvalid_nxt) begin
          w_bready_nxt = 1'b1;
          w_state_nxt  = S_WR_RESP;
        end
      end
      S_WR_RESP: begin
        if (r_bready && m_axi.BVALID) begin
          w_resp_err  = |m_axi.BRESP;
          w_state_nxt = S_DONE;
        end else begin
          w_bready_nxt = 1'b1;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_rdata   <= '0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_addr    <= w_addr_nxt;
      r_wdata   <= w_wdata_nxt;
      r_wstrb   <= w_wstrb_nxt;
      r_rdata   <= w_rdata_nxt;
      r_arvalid <= w_arvalid_nxt;
      r_rready  <= w_rready_nxt;
      r_awvalid <= w_awvalid_nxt;
      r_wvalid  <= w_wvalid_nxt;
      r_bready  <= w_bready_nxt;
    end
  end

  // Stall is combinational so the pipeline freezes in the same cycle a request appears.
  assign stall_o = ((r_state == S_IDLE) && (dmem_ren || dmem_wen)) ||
                   (r_state == S_RD_ADDR) || (r_state == S_RD_DATA) ||
                   (r_state == S_WR_REQ)  || (r_state == S_WR_RESP);

  assign dmem_rdata     = r_rdata;

  assign m_axi.AWID     = AXI_ID_BITS'(MASTER_ID);
  assign m_axi.AWADDR   = r_addr;
  assign m_axi.AWLEN    = AX_LEN;
  assign m_axi.AWSIZE   = AX_SIZE;
  assign m_axi.AWBURST  = AX_BURST;
  assign m_axi.AWVALID  = r_awvalid;
  assign m_axi.WDATA    = r_wdata;
  assign m_axi.WSTRB    = r_wstrb;
  assign m_axi.WLAST    = 1'b1;
  assign m_axi.WVALID   = r_wvalid;
  assign m_axi.BREADY   = r_bready;
  assign m_axi.ARID     = AXI_ID_BITS'(MASTER_ID);
  assign m_axi.ARADDR   = r_addr;
  assign m_axi.ARLEN    = AX_LEN;
  assign m_axi.ARSIZE   = AX_SIZE;
  assign m_axi.ARBURST  = AX_BURST;
  assign m_axi.ARVALID  = r_arvalid;
  assign m_axi.RREADY   = r_rready;

`ifdef DMEM_AXI_ERR_EN
  logic                     r_err;
  logic [AXI_ADDR_BITS-1:0] r_err_addr;

  // Sticky first-error capture; later errors never overwrite the recorded address.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_err      <= 1'b0;
      r_err_addr <= '0;
    end else if (w_resp_err && !r_err) begin
      r_err      <= 1'b1;
      r_err_addr <= r_addr;
    end
  end

  assign err_o      = r_err;
  assign err_addr_o = r_err_addr;

  logic w_unused_ok;
  assign w_unused_ok = ^{m_axi.BID, m_axi.RID, m_axi.RLAST};
`else
  logic w_unused_ok;
  assign w_unused_ok = ^{m_axi.BID, m_axi.RID, m_axi.RLAST, m_axi.RRESP, m_axi.BRESP, w_resp_err};
`endif

endmodule

// File: doc/dmem_axi_master.md
Name: dmem_axi_master

Overview:
- Bridges the CPU data-memory port (dmem_addr/wen/wstrb/wdata/ren/rdata) to an AXI4 master interface (master 1).
- Each CPU request becomes one single-beat AXI transaction.
- Drives a stall that the top level ORs into global_stall_en, freezing the pipeline until the access completes.
- Sits directly downstream of the CPU MEM stage and upstream of the AXI interconnect.

Parameters:
- AXI_ADDR_BITS, 32, address width.
- AXI_DATA_BITS, 32, data width; must equal XLEN.
- AXI_ID_BITS, 4, ID width.
- MASTER_ID, 1, constant driven on AWID/ARID.

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  asynchronous active-low reset
- dmem_addr  in  AXI_ADDR_BITS  CPU access address
- dmem_ren  in  1  read request
- dmem_wen  in  1  write request
- dmem_wstrb  in  AXI_DATA_BITS/8  byte strobes
- dmem_wdata  in  AXI_DATA_BITS  write data
- dmem_rdata  out  AXI_DATA_BITS  read data returned to the MEM stage
- stall_o  out  1  pipeline stall request
- AWID/AWADDR/AWLEN[7:0]/AWSIZE[2:0]/AWBURST[1:0]/AWVALID  out; AWREADY  in
- WDATA/WSTRB/WLAST/WVALID  out; WREADY  in
- BID/BRESP[1:0]/BVALID  in; BREADY  out
- ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  out; ARREADY  in
- RID/RDATA/RRESP/RLAST/RVALID  in; RREADY  out

Behaviour:
- Constants: AxLEN=0, AxSIZE=3'b010, AxBURST=INCR (2'b01), WLAST=1.
- Reset values: FSM=IDLE; all VALID/READY outputs 0; dmem_rdata=0; address/data/strobe registers 0.
- Reset is asynchronous. Asserting it mid-transaction drops every VALID/READY immediately and returns the FSM to IDLE. No completion of the in-flight access is required.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- IDLE:
  - dmem_wen=1 → latch addr/wdata/wstrb; go to WR_REQ.
  - dmem_ren=1 (and wen=0) → latch addr; go to RD_ADDR.
  - wen and ren both 1: the write wins and ren is ignored.
- RD_ADDR: ARVALID=1 (registered, high on state entry). On ARVALID&ARREADY go to RD_DATA.
- RD_DATA: RREADY=1. On RVALID&RREADY, capture RDATA into dmem_rdata and go to DONE. RID and RLAST are not checked.
- WR_REQ:
  - AWVALID and WVALID are asserted together on entry.
  - Each drops independently after its own handshake (aw_done/w_done flags).
  - When both handshakes have happened (same or different cycles), go to WR_RESP.
- WR_RESP: BREADY=1. On BVALID go to DONE.
- DONE: lasts one cycle, then returns to IDLE. New requests are not sampled in DONE.
- AXI rules:
  - Once a VALID is asserted, it and its payload are held stable until READY.
  - Payload comes only from the registers latched in IDLE, never live from the CPU inputs.
- stall_o (combinational):
  - = (state==IDLE & (dmem_ren|dmem_wen)) | state∈{RD_ADDR, RD_DATA, WR_REQ, WR_RESP}.
  - Low in DONE, so the pipeline advances on the DONE clock edge and the CPU presents its next request in the following IDLE cycle.
- dmem_rdata holds its last captured value until the next read completes. It is valid during DONE.
- Minimum latency with READYs already high and the response one cycle later: read = 3 stall cycles, write = 3 stall cycles, DONE on cycle 3.
- AXI error responses (xRESP≠0) are ignored unless the optional feature is compiled in.

Optional Feature:
- Macro: DMEM_AXI_ERR_EN.
- Defined:
  - Adds outputs err_o (1) and err_addr_o (AXI_ADDR_BITS), both reset to 0.
  - When a transaction completes with RRESP≠0 or BRESP≠0, err_o sets sticky and err_addr_o latches the transaction address.
  - Only the first error is recorded; later errors do not overwrite it.
  - Cleared only by reset.
  - Transaction flow is unchanged.
- Undefined: ports absent; responses ignored.

Test Plan:
- Read, ARREADY=1, RVALID one cycle after AR handshake with RDATA=0xDEADBEEF, addr 0x0000_1004 → ARADDR=0x1004, ARLEN=0, ARSIZE=2; stall_o high 3 cycles; dmem_rdata=0xDEADBEEF in DONE.
- Write addr 0x2000, wdata 0x12345678, wstrb 4'b0011; AWREADY delayed 3 cycles, WREADY=1 → W handshakes first; AWVALID and AWADDR stay stable until accepted; BREADY only after both handshakes; stall released in the cycle after BVALID.
- wen=1 and ren=1 together → only AW/W issued; ARVALID stays 0 throughout.
- Back-to-back read then write → a DONE cycle with stall_o=0 separates them; second request sampled in the following IDLE; dmem_rdata keeps the read value during the write.
- ARESETn pulsed low in RD_DATA → RREADY/ARVALID 0 immediately; FSM in IDLE; dmem_rdata=0.
- With DMEM_AXI_ERR_EN: write to 0x3000 with BRESP=2'b10, then read with RRESP=2'b11 → err_o=1; err_addr_o stays 0x3000.
